// File: rtl/stack_mem_pkg.sv
// Shared types and defaults for the stack/memory unit.
// Address-source encodings, FSM states and default widths.
package stack_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;
  localparam int WAIT_DEF   = 1;

  typedef enum logic [1:0] {
    ASEL_PC  = 2'd0,
    ASEL_ALU = 2'd1,
    ASEL_B   = 2'd2,
    ASEL_SP  = 2'd3
  } asel_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic we;
    logic push;
    logic pop;
  } op_t;

endpackage

// File: rtl/stack_mem_ram.sv
// Single-port synchronous RAM, registered read.
// Read data holds while the port is idle.
module stack_mem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/stack_mem_unit.sv
// Memory stage with internal stack pointer and wait states.
// Optional STACK_MEM_BOUNDS_CHECK_EN adds ADDR_ERR and no-wrap checks.
module stack_mem_unit
  import stack_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_STATES = WAIT_DEF,
  parameter int SP_RESET    = DEPTH
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              MW,
  input  logic [1:0]        ASEL,
  input  logic              PUSH,
  input  logic              POP,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALU,
  input  logic [ADDR_W-1:0] B,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] MD,
  output logic              DONE,
  output logic              BUSY,
  output logic [ADDR_W-1:0] SP,
  output logic              SP_OVF,
  output logic              SP_UNF
`ifdef STACK_MEM_BOUNDS_CHECK_EN
  ,
  output logic              ADDR_ERR
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_RESET);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES - 1);

  state_e            state;
  logic [3:0]        cnt;
  logic              ph;
  op_t               op;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;

  logic [ADDR_W-1:0] mux_addr;
  logic [ADDR_W-1:0] eff_addr;
  logic              push_only;
  logic              pop_only;
  logic              blk_ovf;
  logic              blk_unf;
  logic              oob;
  logic              ram_en;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    mux_addr = PC;
    unique case (asel_e'(ASEL))
      ASEL_PC:  mux_addr = PC;
      ASEL_ALU: mux_addr = ALU;
      ASEL_B:   mux_addr = B;
      ASEL_SP:  mux_addr = SP;
    endcase
    push_only = PUSH & ~POP;
    pop_only  = POP & ~PUSH;
    eff_addr  = mux_addr;
    if (push_only)     eff_addr = SP - ADDR_W'(1);
    else if (pop_only) eff_addr = SP;
  end

  assign blk_ovf = op.push && (SP == '0);
  assign blk_unf = op.pop && (SP == SP_RST);

`ifdef STACK_MEM_BOUNDS_CHECK_EN
  assign oob = 32'(op_addr) >= 32'(DEPTH);
`else
  assign oob = 1'b0;
  // Upper address bits are dropped: silent modulo wrap.
  logic unused_addr;
  assign unused_addr = ^op_addr;
`endif

  // RST_N gating keeps a reset edge from committing the write.
  assign ram_en = (state == S_ACCESS) && !ph && RST_N
               && !blk_ovf && !blk_unf && !oob;

  stack_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (CLK),
    .en    (ram_en),
    .we    (op.we),
    .idx   (op_addr[IDX_W-1:0]),
    .wdata (op_data),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ph      <= 1'b0;
      op      <= '0;
      op_addr <= '0;
      op_data <= '0;
      MD      <= '0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      SP      <= SP_RST;
      SP_OVF  <= 1'b0;
      SP_UNF  <= 1'b0;
`ifdef STACK_MEM_BOUNDS_CHECK_EN
      ADDR_ERR <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
`ifdef STACK_MEM_BOUNDS_CHECK_EN
      ADDR_ERR <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (REQ) begin
            op.push <= push_only;
            op.pop  <= pop_only;
            op.we   <= push_only | (MW & ~pop_only);
            op_addr <= eff_addr;
            op_data <= WDATA;
            ph      <= 1'b0;
            BUSY    <= 1'b1;
            cnt     <= WAIT_LD;
            if (WAIT_STATES == 0) state <= S_ACCESS;
            else                  state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_ACCESS;
          else           cnt   <= cnt - 4'd1;
        end
        S_ACCESS: begin
          if (!ph) begin
            ph <= 1'b1;
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
`ifdef STACK_MEM_BOUNDS_CHECK_EN
            ADDR_ERR <= oob;
`endif
            if (!op.we && !blk_unf) MD <= oob ? '0 : rdata;
            if (blk_ovf)      SP_OVF <= 1'b1;
            else if (op.push) SP     <= SP - ADDR_W'(1);
            if (blk_unf)      SP_UNF <= 1'b1;
            else if (op.pop)  SP     <= SP + ADDR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_unit.sv
// Directed vector bench for stack_mem_unit.
// Three builds: default, DEPTH=4/WAIT=0, WAIT=3.
module tb_stack_mem_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic        mw;
  logic [1:0]  asel;
  logic        push;
  logic        pop;
  logic [15:0] pc;
  logic [15:0] alu;
  logic [15:0] b;
  logic [15:0] wdata;
  logic [15:0] md [3];
  logic [15:0] sp [3];
  logic [2:0]  done;
  logic [2:0]  busy;
  logic [2:0]  ovf;
  logic [2:0]  unf;
`ifdef STACK_MEM_BOUNDS_CHECK_EN
  logic [2:0]  aerr;
  localparam logic [15:0] WRAP_MD = 16'h5555;
`else
  localparam logic [15:0] WRAP_MD = 16'h1234;
`endif

  int nvec = 0;
  int errs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stack_mem_unit #(.WAIT_STATES(1)) u0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req[0]), .MW(mw), .ASEL(asel),
    .PUSH(push), .POP(pop), .PC(pc), .ALU(alu), .B(b), .WDATA(wdata),
    .MD(md[0]), .DONE(done[0]), .BUSY(busy[0]), .SP(sp[0]),
    .SP_OVF(ovf[0]), .SP_UNF(unf[0])
`ifdef STACK_MEM_BOUNDS_CHECK_EN
    , .ADDR_ERR(aerr[0])
`endif
  );

  stack_mem_unit #(.DEPTH(4), .WAIT_STATES(0)) u4 (
    .CLK(clk), .RST_N(rst_n), .REQ(req[1]), .MW(mw), .ASEL(asel),
    .PUSH(push), .POP(pop), .PC(pc), .ALU(alu), .B(b), .WDATA(wdata),
    .MD(md[1]), .DONE(done[1]), .BUSY(busy[1]), .SP(sp[1]),
    .SP_OVF(ovf[1]), .SP_UNF(unf[1])
`ifdef STACK_MEM_BOUNDS_CHECK_EN
    , .ADDR_ERR(aerr[1])
`endif
  );

  stack_mem_unit #(.WAIT_STATES(3)) u3 (
    .CLK(clk), .RST_N(rst_n), .REQ(req[2]), .MW(mw), .ASEL(asel),
    .PUSH(push), .POP(pop), .PC(pc), .ALU(alu), .B(b), .WDATA(wdata),
    .MD(md[2]), .DONE(done[2]), .BUSY(busy[2]), .SP(sp[2]),
    .SP_OVF(ovf[2]), .SP_UNF(unf[2])
`ifdef STACK_MEM_BOUNDS_CHECK_EN
    , .ADDR_ERR(aerr[2])
`endif
  );

  typedef struct {
    bit          mw;
    logic [1:0]  asel;
    bit          push;
    bit          pop;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] md;
    logic [15:0] sp;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic op(input int u, input bit m, input logic [1:0] as,
                    input bit pu, input bit po, input logic [15:0] a,
                    input logic [15:0] d, output int lat);
    @(negedge clk);
    mw = m; asel = as; push = pu; pop = po; wdata = d;
    pc = 16'h0FF0; alu = 16'h0EE0; b = 16'h0DD0;
    case (as)
      2'd0: pc = a;
      2'd1: alu = a;
      2'd2: b = a;
      default: ;
    endcase
    req[u] = 1'b1;
    @(posedge clk);
    #1;
    req[u] = 1'b0;
    wdata = ~d; pc = 16'h5A5A; alu = 16'hA5A5; b = 16'h3C3C;
    mw = ~m; push = ~pu; pop = ~po;
    chk("busy", 32'(busy[u]), 32'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done[u]) break;
    end
    if (lat < 40) begin
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(done[u]), 32'd0);
    end
    push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    int lat;
    int nd;
    rst_n = 1'b0; req = '0; mw = 0; asel = 0; push = 0; pop = 0;
    pc = 0; alu = 0; b = 0; wdata = 0;

    tv[0]  = '{1, 2'd2, 0, 0, 16'h0001, 16'h0022, 16'h0000, 16'd256, 0, 0};
    tv[1]  = '{0, 2'd2, 0, 0, 16'h0001, 16'h0000, 16'h0022, 16'd256, 0, 0};
    tv[2]  = '{1, 2'd1, 0, 0, 16'h00F3, 16'h0744, 16'h0022, 16'd256, 0, 0};
    tv[3]  = '{0, 2'd1, 0, 0, 16'h00F3, 16'h0000, 16'h0744, 16'd256, 0, 0};
    tv[4]  = '{0, 2'd0, 0, 0, 16'h0001, 16'h0000, 16'h0022, 16'd256, 0, 0};
    tv[5]  = '{0, 2'd0, 1, 0, 16'h0033, 16'hFF00, 16'h0022, 16'd255, 0, 0};
    tv[6]  = '{1, 2'd2, 0, 1, 16'h0033, 16'h0000, 16'hFF00, 16'd256, 0, 0};
    tv[7]  = '{0, 2'd3, 0, 1, 16'h0000, 16'h0000, 16'hFF00, 16'd256, 0, 1};
    tv[8]  = '{1, 2'd2, 0, 0, 16'h0005, 16'h5555, 16'hFF00, 16'd256, 0, 1};
    tv[9]  = '{1, 2'd2, 0, 0, 16'h0105, 16'h1234, 16'hFF00, 16'd256, 0, 1};
    tv[10] = '{0, 2'd2, 0, 0, 16'h0005, 16'h0000, WRAP_MD, 16'd256, 0, 1};
    tv[11] = '{1, 2'd2, 1, 1, 16'h0010, 16'hABCD, WRAP_MD, 16'd256, 0, 1};
    tv[12] = '{0, 2'd2, 0, 0, 16'h0010, 16'h0000, 16'hABCD, 16'd256, 0, 1};
    tv[13] = '{0, 2'd0, 1, 0, 16'h0077, 16'h0BEE, 16'hABCD, 16'd255, 0, 1};
    tv[14] = '{0, 2'd3, 0, 0, 16'h0000, 16'h0000, 16'h0BEE, 16'd255, 0, 1};
    tv[15] = '{0, 2'd3, 0, 1, 16'h0000, 16'h0000, 16'h0BEE, 16'd256, 0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_md", 32'(md[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_sp", 32'(sp[0]), 32'd256);
    chk("rst_flags", 32'({ovf[0], unf[0]}), 32'd0);
    chk("rst_sp4", 32'(sp[1]), 32'd4);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      op(0, tv[i].mw, tv[i].asel, tv[i].push, tv[i].pop,
         tv[i].addr, tv[i].wdata, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_md", i), 32'(md[0]), 32'(tv[i].md));
      chk($sformatf("v%0d_sp", i), 32'(sp[0]), 32'(tv[i].sp));
      chk($sformatf("v%0d_ovf", i), 32'(ovf[0]), 32'(tv[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(unf[0]), 32'(tv[i].unf));
    end

    // Reset during WAIT of a write aborts it.
    @(negedge clk);
    mw = 1; asel = 2'd2; b = 16'h0001; wdata = 16'h9999; req[0] = 1'b1;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done[0]) nd++;
    end
    chk("abort_done", 32'(nd), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_unf", 32'(unf[0]), 32'd0);
    chk("abort_sp", 32'(sp[0]), 32'd256);
    op(0, 0, 2'd2, 0, 0, 16'h0001, 16'h0000, lat);
    chk("abort_rd", 32'(md[0]), 32'h0022);

    op(0, 0, 2'd0, 0, 1, 16'h0000, 16'h0000, lat);
    chk("unf_flag", 32'(unf[0]), 32'd1);
    chk("unf_sp", 32'(sp[0]), 32'd256);
    chk("unf_md", 32'(md[0]), 32'h0022);
    chk("unf_lat", 32'(lat), 32'd3);

    for (int i = 0; i < 5; i++) begin
      op(1, 0, 2'd0, 1, 0, 16'h0000, 16'(i + 1), lat);
      chk($sformatf("d4_push%0d_lat", i), 32'(lat), 32'd2);
      chk($sformatf("d4_push%0d_sp", i), 32'(sp[1]),
          (i < 4) ? 32'(3 - i) : 32'd0);
      chk($sformatf("d4_push%0d_ovf", i), 32'(ovf[1]),
          (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 2'd0, 0, 1, 16'h0000, 16'h0000, lat);
      chk($sformatf("d4_pop%0d_md", i), 32'(md[1]), 32'(4 - i));
      chk($sformatf("d4_pop%0d_sp", i), 32'(sp[1]), 32'(i + 1));
    end

    op(2, 1, 2'd2, 0, 0, 16'h0042, 16'h7777, lat);
    chk("w3_wr_lat", 32'(lat), 32'd5);
    op(2, 0, 2'd2, 0, 0, 16'h0042, 16'h0000, lat);
    chk("w3_rd_lat", 32'(lat), 32'd5);
    chk("w3_rd_md", 32'(md[2]), 32'h7777);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/stack_mem_unit.md
Name: stack_mem_unit

Overview:
- Parametrised successor to the 16-bit integrated CPU memory stage.
- One synchronous RAM with a 4-way address mux (PC, ALU, B, SP), a req/done handshake and configurable wait states.
- Owns the stack pointer internally, with push/pop and overflow/underflow detection.
- Sits between the control unit and the register file; MD feeds the IR and MDR.

Parameters:
DATA_W, 16, data and register width
ADDR_W, 16, width of address inputs and SP
DEPTH, 256, RAM words; must be <= 2**ADDR_W
WAIT_STATES, 1, extra cycles per access (0..15)
SP_RESET, DEPTH, SP value after reset (empty stack, grows down)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  synchronous active-low reset
REQ  in  1  access request, sampled only in IDLE
MW  in  1  1 = write, 0 = read (ignored for push/pop)
ASEL  in  2  address source: 0 PC, 1 ALU, 2 B, 3 SP
PUSH  in  1  stack push: write WDATA at SP-1, SP--
POP  in  1  stack pop: read at SP, SP++
PC  in  ADDR_W  program counter
ALU  in  ADDR_W  ALU result address
B  in  ADDR_W  register B address
WDATA  in  DATA_W  write data
MD  out  DATA_W  read data, held until next read completes
DONE  out  1  one-cycle pulse when access completes
BUSY  out  1  high outside IDLE
SP  out  ADDR_W  current stack pointer
SP_OVF  out  1  sticky: push attempted with SP==0
SP_UNF  out  1  sticky: pop attempted with SP==SP_RESET

Behaviour:
- Reset (RST_N low at an edge): state IDLE, MD=0, DONE=0, BUSY=0, SP=SP_RESET, flags=0. RAM contents are not reset.
- Reset mid-operation aborts the access: no write, no DONE.
- FSM IDLE -> WAIT -> ACCESS -> IDLE. With WAIT_STATES=0 the FSM goes IDLE -> ACCESS.
- IDLE, REQ=1: latch MW, PUSH, POP, WDATA and the effective address; BUSY rises next cycle.
  - Effective address is the ASEL mux, overridden by SP-1 on push and SP on pop.
- WAIT: counter loads WAIT_STATES-1 and decrements to 0, then the FSM enters ACCESS.
- ACCESS performs the RAM operation. Next cycle: DONE=1 for one cycle, state IDLE, MD updated on reads/pops.
  - DONE latency is exactly WAIT_STATES+2 cycles after the REQ sampling edge.
- REQ while BUSY is ignored (not queued). Inputs may change freely while BUSY.
- SP updates in ACCESS, so a back-to-back push then pop sees the new SP.
- Push with SP==0: no write, SP unchanged, SP_OVF set, DONE still pulses.
- Pop with SP==SP_RESET: no read (MD holds), SP unchanged, SP_UNF set, DONE still pulses.
- PUSH and POP both high: treated as a plain access per MW/ASEL; SP unchanged, no flag.
- Address wraps modulo DEPTH: only the low log2(DEPTH) bits index the RAM.
- Write-then-read of the same address returns the new data (read occurs in a later ACCESS).
- Flags clear only on reset.

Optional Feature:
- STACK_MEM_BOUNDS_CHECK_EN defined: effective address >= DEPTH is not wrapped.
  - Write suppressed; read returns 0.
  - Extra output ADDR_ERR pulses together with DONE.
- Undefined: silent modulo wrap as above; no ADDR_ERR port.

Decomposition:
- Shared package stack_mem_pkg:
  - ASEL encodings (ASEL_PC, ASEL_ALU, ASEL_B, ASEL_SP).
  - FSM state typedef (S_IDLE, S_WAIT, S_ACCESS).
  - Default widths.
- One natural sub-module, stack_mem_ram: single-port synchronous RAM, DATA_W x DEPTH, write enable, registered read.
- FSM, SP and mux stay in the top.

Test Plan:
- Reset, then REQ MW=1 ASEL=2 B=0x0001 WDATA=0x0022, then a read at the same address -> DONE after WAIT_STATES+2 cycles, MD=0x0022.
- Write 0x0744 at ALU=0x00F3, then read ASEL=1 -> MD=0x0744, and address 0x0001 still reads 0x0022.
- PUSH 0xFF00 then POP -> SP 256->255->256, MD=0xFF00, no flags.
- POP right after reset -> SP_UNF=1, SP=256, MD unchanged.
- DEPTH=4: push five times -> fifth push sets SP_OVF, SP=0.
- Reset asserted during WAIT of a write -> no DONE, target word unchanged on readback.
- WAIT_STATES=0 and WAIT_STATES=3 builds -> DONE exactly 2 and 5 cycles after REQ.
